// File: rtl/mux_ser_sequencer_if.sv
// mux_ser_sequencer_if
// Bundles the three sides of the sequencer that are not clock/reset:
//   upstream word handshake : in_valid, in_ready, in_data
//   MuxMod drive/return     : mux_s, mux_d, mux_o
//   downstream serial beat  : ser_valid, ser_ready, ser_bit, ser_first, ser_last
// slave  : the sequencer itself
// master : everything around it (word source, MuxMod, serial consumer)
interface mux_ser_if;
    logic       in_valid;
    logic       in_ready;
    logic [0:7] in_data;    // bit 0 is the leftmost bit of the word

    logic [2:0] mux_s;
    logic [0:7] mux_d;
    logic       mux_o;

    logic       ser_valid;
    logic       ser_ready;
    logic       ser_bit;
    logic       ser_first;
    logic       ser_last;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mux_s,
        output mux_d,
        input  mux_o,
        output ser_valid,
        input  ser_ready,
        output ser_bit,
        output ser_first,
        output ser_last
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mux_s,
        input  mux_d,
        output mux_o,
        input  ser_valid,
        output ser_ready,
        input  ser_bit,
        input  ser_first,
        input  ser_last
    );
endinterface

// File: rtl/mux_ser_sequencer.sv
// mux_ser_sequencer
// Parallel-to-serial controller wrapped around the 8x1 MuxMod. A word
// accepted on the in_* handshake is held on mux_d while mux_s walks the
// eight positions, one position per accepted serial beat. The mux output
// returns on mux_o and is forwarded as ser_bit with first/last framing.
//
// Ports
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : mux_ser_if.slave (word input, MuxMod drive/return, serial output)
//
// Parameter
//   DIR  : 0 = ascending select (d[0] first), 1 = descending (d[7] first)
//
// State table
//   state    | meaning
//   ST_IDLE  | no word held; ready to accept a new word
//   ST_SHIFT | word held on mux_d; presenting beat cnt on ser_*
module mux_ser_sequencer #(
    parameter bit DIR = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    mux_ser_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [2:0] CNT_LAST = 3'd7;
    localparam logic [2:0] SEL_RST  = DIR ? 3'd7 : 3'd0;

    state_t     state_q, state_d;
    logic [2:0] cnt_q,   cnt_d;
    logic [0:7] data_q,  data_d;
    logic [2:0] sel_q,   sel_d;

    logic       in_ready_c;
    logic       ser_valid_c;
    logic       cnt_last;
    logic       beat_hs;

    assign cnt_last = (cnt_q == CNT_LAST);
    assign beat_hs  = ser_valid_c & bus.ser_ready;

    // State register. mux_s is registered from the next count so that it
    // always lines up with cnt in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            data_q  <= 8'b0;
            sel_q   <= SEL_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        in_ready_c  = 1'b0;
        ser_valid_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    cnt_d   = 3'd0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                ser_valid_c = 1'b1;
                // A new word can slip in on the same edge that retires the
                // last beat, which gives back-to-back words with no gap.
                in_ready_c  = cnt_last & bus.ser_ready;
                if (beat_hs) begin
                    if (!cnt_last) begin
                        cnt_d = cnt_q + 3'd1;
                    end else begin
                        cnt_d = 3'd0;
                        if (bus.in_valid) begin
                            data_d = bus.in_data;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase

        sel_d = DIR ? (CNT_LAST - cnt_d) : cnt_d;
    end

    // Handshake outputs are forced low while rst is high so that a word in
    // flight stops emitting beats in the very cycle reset is applied.
    assign bus.in_ready  = in_ready_c  & ~rst;
    assign bus.ser_valid = ser_valid_c & ~rst;

    assign bus.mux_s     = sel_q;
    assign bus.mux_d     = data_q;

    // ser_bit passes the mux output straight through; it only has to settle
    // within the cycle after mux_s/mux_d update.
    assign bus.ser_bit   = bus.ser_valid & bus.mux_o;
    assign bus.ser_first = bus.ser_valid & (cnt_q == 3'd0);
    assign bus.ser_last  = bus.ser_valid & cnt_last;

endmodule

// File: doc/mux_ser_sequencer.md
# mux_ser_sequencer

Parallel-to-serial controller that drives the select and data inputs of the gate-level 8x1 multiplexor (MuxMod) and frames its output as a serial bit stream. It accepts one 8-bit word per valid/ready handshake, holds it on the mux data inputs, and steps the mux select through all eight positions, one per accepted output beat. It returns the mux output to a downstream consumer with valid/ready, first and last flags. It sits directly upstream of MuxMod and wraps its combinational path.

## Interface
- DIR, 0, select order: 0 = ascending (s = 0..7, d[0] first); 1 = descending (s = 7..0, d[7] first)
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream word available
- in_ready  out  1  block can accept a word this cycle
- in_data  in  [0:7]  parallel word, bit 0 is leftmost
- mux_s  out  [2:0]  select to MuxMod s, registered
- mux_d  out  [0:7]  data to MuxMod d, registered
- mux_o  in  1  MuxMod output o
- ser_valid  out  1  ser_bit is a valid beat
- ser_ready  in  1  downstream accepts the beat
- ser_bit  out  1  serial bit; equals mux_o when ser_valid is 1, else 0
- ser_first  out  1  beat is bit 0 of the word (cnt == 0)
- ser_last  out  1  beat is bit 7 of the word (cnt == 7)

## Operation
- States: IDLE and SHIFT. The internal 3-bit beat counter is cnt.
- mux_s = cnt when DIR = 0; mux_s = 7 - cnt when DIR = 1.
- Reset, sampled on clk:
  - state = IDLE, cnt = 0, mux_d = 8'b0
  - mux_s = 0 (DIR = 0) or 7 (DIR = 1)
  - ser_valid = 0, in_ready = 0 while rst is high
- IDLE:
  - in_ready = 1, ser_valid = 0, ser_bit = 0, ser_first = 0, ser_last = 0.
  - When in_valid is 1: mux_d <= in_data, cnt <= 0, go to SHIFT.
- SHIFT:
  - ser_valid = 1, ser_bit = mux_o, and the first/last flags are decoded from cnt.
  - Beat handshake = ser_valid & ser_ready.
  - On a handshake with cnt < 7: cnt <= cnt + 1.
  - On a handshake with cnt == 7:
    - If in_valid is 1, load the new word (mux_d <= in_data), set cnt <= 0 and stay in SHIFT. This is the back-to-back case.
    - Otherwise go to IDLE with cnt <= 0.
  - No handshake: cnt, mux_d and mux_s hold. ser_bit stays stable because its inputs are unchanged.
- in_ready = (state == IDLE) | (state == SHIFT & cnt == 7 & ser_ready), gated low during rst.
- mux_d is frozen from acceptance until the last beat handshakes. Changes on in_data during SHIFT are ignored.
- rst mid-word: the partial word is discarded. Next cycle state = IDLE, ser_valid = 0, and no further beats of that word are emitted.
- cnt wraps only through reload. It never advances without a handshake.

## Timing
- Acceptance in cycle N: mux_d and mux_s are valid from N+1.
- ser_bit is combinational from mux_o through MuxMod gate delay. It must settle within the cycle in which mux_s and mux_d are registered.
- Beat k (k = 0..7) is presented from cycle N+1+k when ser_ready is held at 1, so latency from acceptance to the first beat is 1 cycle.
- Sustained throughput is 8 cycles per word, with no idle gap when back-to-back.
- Each cycle that ser_ready is low while ser_valid is high delays all remaining beats by one cycle.

## Test plan
- Reset with rst = 1 for 2 cycles, DIR = 0 -> ser_valid = 0, mux_s = 0, mux_d = 8'b0 and in_ready = 0 during reset. in_ready = 1 in the first cycle after reset.
- Accept in_data = 8'b10110010 at cycle N with ser_ready = 1 -> ser_bit = 1,0,1,1,0,0,1,0 on cycles N+1..N+8, with mux_s = 0..7 over those cycles. ser_first is high only at N+1 and ser_last only at N+8. The block returns to IDLE at N+9.
- Back-to-back: 8'hFF, then 8'h00 presented with in_valid held high -> second word is accepted at N+8. Output is 8 ones then 8 zeros with no gap, and ser_first is high at N+9.
- Stall: 8'b01000000 with ser_ready low on cycles N+2..N+4 -> the bit-1 beat (value 1, mux_s = 1) holds for 4 cycles. Total of 8 beats and ser_last is at N+11.
- DIR = 1, in_data = 8'b10110010 -> mux_s = 7..0 and ser_bit = 0,1,0,0,1,1,0,1.
- rst asserted at beat 3 of a word -> ser_valid = 0 next cycle and in_ready = 1 the cycle after rst drops. A new word 8'hA5 then streams 1,0,1,0,0,1,0,1 from beat 0.
